instr_pack: RTL

Instruction assembler: the encode-side counterpart of the field-separation stage. Accepts decoded MIPS-style fields over a valid/ready handshake, packs them into a 32-bit instruction word in R, I or J format by opcode, and writes the words sequentially into an instruction memory port. Sits between the test/loader front end and the instruction memory that the multi-cycle datapath fetches from.

---
 rtl/instr_defs.sv | 39 +++
 rtl/instr_encode.sv | 32 +++
 rtl/instr_pack.sv | 118 +++++++++++
 3 files changed

// File: rtl/instr_defs.sv
// Shared instruction-format definitions: FSM state codes, opcode constants,
// field bit positions and the captured field-set record.
package instr_defs;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PACK  = 3'd1,
      ST_WRITE = 3'd2,
      ST_FULL  = 3'd3
   } state_t;

   // Opcodes that select a non-I format
   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_JAL   = 6'd3;

   // Field LSB positions inside the 32-bit word (shared with the field-separation stage)
   localparam int OPCODE_LSB = 26;
   localparam int RS_LSB     = 21;
   localparam int RT_LSB     = 16;
   localparam int RD_LSB     = 11;
   localparam int SHAMT_LSB  = 6;
   localparam int FUNC_LSB   = 0;
   localparam int IMM_LSB    = 0;
   localparam int TARGET_LSB = 0;

   // Every decoded field, captured together at the accepting edge
   typedef struct packed {
      logic [5:0]  opcode;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [5:0]  func;
      logic [15:0] immediate;
      logic [25:0] target;
   } fields_t;

endpackage

// File: rtl/instr_encode.sv
// Combinational packer: selects R, I or J layout from the opcode and places
// the relevant fields; fields not used by the chosen format are ignored.
module instr_encode
   import instr_defs::*;
(
   input  logic [$bits(fields_t)-1:0] i_fields,
   output logic [31:0]                o_word
);

   fields_t w_f;
   assign w_f = fields_t'(i_fields);

   // Build the word for the format implied by the opcode
   always_comb begin
      o_word = '0;
      o_word[OPCODE_LSB +: 6] = w_f.opcode;
      if (w_f.opcode == OP_RTYPE) begin
         o_word[RS_LSB    +: 5] = w_f.rs;
         o_word[RT_LSB    +: 5] = w_f.rt;
         o_word[RD_LSB    +: 5] = w_f.rd;
         o_word[SHAMT_LSB +: 5] = w_f.shamt;
         o_word[FUNC_LSB  +: 6] = w_f.func;
      end else if ((w_f.opcode == OP_J) || (w_f.opcode == OP_JAL)) begin
         o_word[TARGET_LSB +: 26] = w_f.target;
      end else begin
         o_word[RS_LSB  +: 5]  = w_f.rs;
         o_word[RT_LSB  +: 5]  = w_f.rt;
         o_word[IMM_LSB +: 16] = w_f.immediate;
      end
   end

endmodule

// File: rtl/instr_pack.sv
// Instruction assembler: accepts a field set in IDLE, packs it in PACK, writes
// it to the next instruction-memory address in WRITE, and stops in FULL once
// DEPTH words are stored. All outputs decode registered state only.
// DEPTH must not exceed 2**ADDR_W.
module instr_pack
   import instr_defs::*;
#(
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        opcode,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [4:0]        rd,
   input  logic [4:0]        shamt,
   input  logic [5:0]        func,
   input  logic [15:0]       immediate,
   input  logic [25:0]       target,
   input  logic              clear,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [ADDR_W:0]   word_count,
   output logic              full
);

   localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

   state_t              r_state;
   state_t              w_state_next;
   fields_t             r_fields;
   fields_t             w_fields_in;
   logic [31:0]         r_word;
   logic [31:0]         w_word;
   logic [ADDR_W-1:0]   r_wr_ptr;
   logic [ADDR_W:0]     r_word_count;
   logic [ADDR_W:0]     w_count_inc;

   assign w_fields_in = '{opcode:    opcode,
                          rs:        rs,
                          rt:        rt,
                          rd:        rd,
                          shamt:     shamt,
                          func:      func,
                          immediate: immediate,
                          target:    target};

   assign w_count_inc = r_word_count + 1'b1;

   instr_encode u_encode (
      .i_fields (r_fields),
      .o_word   (w_word)
   );

   // Next-state logic; clear overrides every transition
   always_comb begin
      w_state_next = r_state;
      if (clear) begin
         w_state_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:  if (in_valid) w_state_next = ST_PACK;
            ST_PACK:  w_state_next = ST_WRITE;
            ST_WRITE: w_state_next = (w_count_inc == DEPTH_C) ? ST_FULL : ST_IDLE;
            ST_FULL:  w_state_next = ST_FULL;
            default:  w_state_next = ST_IDLE;
         endcase
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   // Capture the field set on the accepting edge only
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_fields <= '0;
      else if ((r_state == ST_IDLE) && in_valid && !clear)
         r_fields <= w_fields_in;
   end

   // Packed-word register, loaded in PACK; clear leaves it untouched
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_word <= '0;
      else if ((r_state == ST_PACK) && !clear)
         r_word <= w_word;
   end

   // Write pointer and word count advance after each committed write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr     <= '0;
         r_word_count <= '0;
      end else if (clear) begin
         r_wr_ptr     <= '0;
         r_word_count <= '0;
      end else if (r_state == ST_WRITE) begin
         r_wr_ptr     <= r_wr_ptr + 1'b1;
         r_word_count <= w_count_inc;
      end
   end

   assign in_ready   = (r_state == ST_IDLE);
   assign mem_we     = (r_state == ST_WRITE);
   assign full       = (r_state == ST_FULL);
   assign mem_addr   = r_wr_ptr;
   assign mem_wdata  = r_word;
   assign word_count = r_word_count;

endmodule
